id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Captures decoded instruction fields each cycle and resolves forwarding from the MEM and WB stages.
- Performs immediate extension and shift-amount selection, then presents the final portA, portB and aluop that drive the ALU interface.
- Honours hazard-unit stall and flush; the EX-stage consumer sees one valid-qualified operand set per cycle.

Parameters:
- DW, 32, datapath width (fixed at 32 for MIPS; immediate extension assumes 32)
- RW, 5, register index width
- OPW, 4, ALU opcode width (same encoding as the shared ALU opcode enum)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  synchronous active-low reset
- stall  in  1  hold current EX contents
- flush  in  1  insert bubble into EX
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DW  instruction PC
- id_rs, id_rt  in  RW  source register indices
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_dest  in  RW  destination register
- id_imm16  in  16  instruction immediate
- id_shamt  in  5  shift amount field
- id_aluop  in  OPW  ALU opcode
- id_alusrc  in  2  00 rt, 01 sign-ext imm, 10 zero-ext imm, 11 imm<<16 (LUI)
- id_shift  in  1  SLL/SRL form: operands are rt and shamt
- id_regwen, id_memread, id_memwrite  in  1  control bits
- mem_regwen  in  1  MEM-stage write enable
- mem_dest  in  RW  MEM-stage destination
- mem_result  in  DW  MEM-stage ALU result
- wb_regwen  in  1  WB-stage write enable
- wb_dest  in  RW  WB-stage destination
- wb_data  in  DW  WB-stage write data
- ex_valid  out  1  EX holds a real instruction
- ex_portA, ex_portB  out  DW  ALU operands
- ex_aluop  out  OPW  ALU opcode
- ex_store_data  out  DW  forwarded rt value for stores
- ex_dest  out  RW  destination register
- ex_regwen, ex_memread, ex_memwrite  out  1  gated control bits
- ex_pc  out  DW  PC of EX instruction

Behaviour:
- Reset: on a rising CLK edge with nRST=0, all latched state clears to 0. All outputs read 0 (ex_valid=0, operands 0, aluop 0) from the next cycle. Reset overrides stall and flush. Reset mid-stall discards the held instruction.
- Capture: on each edge with nRST=1, stall=0, flush=0, every id_* field is latched and ex_valid<=id_valid. Latency is exactly one cycle from ID to EX.
- Flush: on an edge with flush=1, ex_valid<=0 and control bits are cleared. Data fields are don't-care. Flush wins over stall.
- Stall: on an edge with stall=1, flush=0, all fields hold. Exception (stall refresh): if wb_regwen=1 and wb_dest!=0 and wb_dest equals the latched rs (resp. rt), the latched rs_data (resp. rt_data) is overwritten with wb_data. This prevents loss of a WB value that retires during the stall.
- Forwarding (combinational within the EX cycle, applied to the latched rs and rt):
  - Source is mem_result if mem_regwen=1, mem_dest!=0 and mem_dest==idx.
  - Else wb_data if wb_regwen=1, wb_dest!=0 and wb_dest==idx.
  - Else the latched register data.
  - MEM takes priority over WB. Register $0 is never forwarded and always uses latched data.
- Operand select:
  - id_shift=1: portA = fwd_rt, portB = {27'b0, shamt}.
  - Otherwise portA = fwd_rs, and portB is selected by alusrc:
    - 00: fwd_rt
    - 01: sign-extended imm16
    - 10: zero-extended imm16
    - 11: {imm16, 16'b0}
  - ex_store_data = fwd_rt always.
- Bubble gating: when ex_valid=0, ex_regwen, ex_memread and ex_memwrite are driven 0 regardless of latched values. Operands and aluop may carry stale data.
- No internal FSM beyond the valid/hold register. There is no handshake other than stall/flush, which come from the hazard unit.

Test Plan:
- Reset with stall=1 and flush=0 for 2 cycles, then nRST=1 with id_valid=0 -> all outputs 0 and ex_valid=0 throughout.
- ADDI $3,$1,-4 with id_rs_data=0x10, imm16=0xFFFC, alusrc=01 -> next cycle portA=0x10, portB=0xFFFFFFFC, ex_valid=1, ex_regwen=1.
- Latched rs=2, rt=2; mem_dest=2 (mem_result=0xAAAA) and wb_dest=2 (wb_data=0xBBBB) both enabled -> portA=0xAAAA. Then mem_regwen=0 -> portA=0xBBBB. Repeat with rs=0 and mem_dest=0 -> latched data is used.
- SLL $4,$5,7 with id_shift=1 and rt_data=0x3 -> portA=0x3, portB=7. LUI with imm16=0x1234, alusrc=11 -> portB=0x12340000.
- Hold stall=1 for 3 cycles while wb writes rt=6 with 0xCAFE in cycle 2, then release -> outputs held during the stall, ex_store_data=0xCAFE after wb deasserts.
- Assert stall=1 and flush=1 together on an SW instruction -> next cycle ex_valid=0 and ex_memwrite=0. The following capture proceeds normally.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_operand_stage_if
//  Description : Bundle connecting the ID stage, hazard unit and MEM/WB
//                bypass sources to the ID/EX operand stage, plus the operand
//                set presented to the EX stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_operand_stage_if #(
    parameter int DW  = 32,
    parameter int RW  = 5,
    parameter int OPW = 4
);
    // hazard unit
    logic           stall;
    logic           flush;

    // decoded instruction from ID
    logic           id_valid;
    logic [DW-1:0]  id_pc;
    logic [RW-1:0]  id_rs;
    logic [RW-1:0]  id_rt;
    logic [DW-1:0]  id_rs_data;
    logic [DW-1:0]  id_rt_data;
    logic [RW-1:0]  id_dest;
    logic [15:0]    id_imm16;
    logic [4:0]     id_shamt;
    logic [OPW-1:0] id_aluop;
    logic [1:0]     id_alusrc;
    logic           id_shift;
    logic           id_regwen;
    logic           id_memread;
    logic           id_memwrite;

    // bypass sources
    logic           mem_regwen;
    logic [RW-1:0]  mem_dest;
    logic [DW-1:0]  mem_result;
    logic           wb_regwen;
    logic [RW-1:0]  wb_dest;
    logic [DW-1:0]  wb_data;

    // EX-stage operand set
    logic           ex_valid;
    logic [DW-1:0]  ex_portA;
    logic [DW-1:0]  ex_portB;
    logic [OPW-1:0] ex_aluop;
    logic [DW-1:0]  ex_store_data;
    logic [RW-1:0]  ex_dest;
    logic           ex_regwen;
    logic           ex_memread;
    logic           ex_memwrite;
    logic [DW-1:0]  ex_pc;

    // Pipeline/hazard side: drives ID fields and bypass sources, observes EX
    modport master (
        output stall, flush,
        output id_valid, id_pc, id_rs, id_rt, id_rs_data, id_rt_data, id_dest,
        output id_imm16, id_shamt, id_aluop, id_alusrc, id_shift,
        output id_regwen, id_memread, id_memwrite,
        output mem_regwen, mem_dest, mem_result,
        output wb_regwen, wb_dest, wb_data,
        input  ex_valid, ex_portA, ex_portB, ex_aluop, ex_store_data,
        input  ex_dest, ex_regwen, ex_memread, ex_memwrite, ex_pc
    );

    // Operand stage side
    modport slave (
        input  stall, flush,
        input  id_valid, id_pc, id_rs, id_rt, id_rs_data, id_rt_data, id_dest,
        input  id_imm16, id_shamt, id_aluop, id_alusrc, id_shift,
        input  id_regwen, id_memread, id_memwrite,
        input  mem_regwen, mem_dest, mem_result,
        input  wb_regwen, wb_dest, wb_data,
        output ex_valid, ex_portA, ex_portB, ex_aluop, ex_store_data,
        output ex_dest, ex_regwen, ex_memread, ex_memwrite, ex_pc
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_operand_stage
//  Description : ID/EX pipeline register feeding the ALU. Latches decoded
//                fields, resolves MEM/WB forwarding on the latched sources,
//                extends the immediate and selects the final ALU operands.
//                Stall holds the stage (refreshing sources retiring from WB),
//                flush inserts a bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
    parameter int DW  = 32,
    parameter int RW  = 5,
    parameter int OPW = 4
) (
    input  wire logic             CLK,
    input  wire logic             nRST,
    id_ex_operand_stage_if.slave  bus
);

    // operand-B source encodings
    localparam logic [1:0]    c_SRC_RT   = 2'b00;
    localparam logic [1:0]    c_SRC_SEXT = 2'b01;
    localparam logic [1:0]    c_SRC_ZEXT = 2'b10;
    localparam logic [1:0]    c_SRC_LUI  = 2'b11;
    localparam logic [RW-1:0] c_REG_ZERO = '0;

    // latched EX-stage state
    logic           r_valid;
    logic [DW-1:0]  r_pc;
    logic [RW-1:0]  r_rs;
    logic [RW-1:0]  r_rt;
    logic [DW-1:0]  r_rs_data;
    logic [DW-1:0]  r_rt_data;
    logic [RW-1:0]  r_dest;
    logic [15:0]    r_imm16;
    logic [4:0]     r_shamt;
    logic [OPW-1:0] r_aluop;
    logic [1:0]     r_alusrc;
    logic           r_shift;
    logic           r_regwen;
    logic           r_memread;
    logic           r_memwrite;

    // bypass match terms; $0 never matches
    logic           w_mem_hit_rs;
    logic           w_mem_hit_rt;
    logic           w_wb_hit_rs;
    logic           w_wb_hit_rt;
    logic [DW-1:0]  w_fwd_rs;
    logic [DW-1:0]  w_fwd_rt;
    logic [DW-1:0]  w_imm_ext;
    logic [DW-1:0]  w_portA;
    logic [DW-1:0]  w_portB;

    assign w_mem_hit_rs = bus.mem_regwen && (bus.mem_dest != c_REG_ZERO) && (bus.mem_dest == r_rs);
    assign w_mem_hit_rt = bus.mem_regwen && (bus.mem_dest != c_REG_ZERO) && (bus.mem_dest == r_rt);
    assign w_wb_hit_rs  = bus.wb_regwen  && (bus.wb_dest  != c_REG_ZERO) && (bus.wb_dest  == r_rs);
    assign w_wb_hit_rt  = bus.wb_regwen  && (bus.wb_dest  != c_REG_ZERO) && (bus.wb_dest  == r_rt);

    // Pipeline register: reset > flush > stall (hold with WB refresh) > capture
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_dest     <= '0;
            r_imm16    <= '0;
            r_shamt    <= '0;
            r_aluop    <= '0;
            r_alusrc   <= '0;
            r_shift    <= 1'b0;
            r_regwen   <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
        end else if (bus.flush) begin
            // bubble: data fields are left as-is, only validity and side effects die
            r_valid    <= 1'b0;
            r_regwen   <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
        end else if (bus.stall) begin
            // a WB write retiring now would otherwise be gone when the stall lifts
            if (w_wb_hit_rs) begin
                r_rs_data <= bus.wb_data;
            end
            if (w_wb_hit_rt) begin
                r_rt_data <= bus.wb_data;
            end
        end else begin
            r_valid    <= bus.id_valid;
            r_pc       <= bus.id_pc;
            r_rs       <= bus.id_rs;
            r_rt       <= bus.id_rt;
            r_rs_data  <= bus.id_rs_data;
            r_rt_data  <= bus.id_rt_data;
            r_dest     <= bus.id_dest;
            r_imm16    <= bus.id_imm16;
            r_shamt    <= bus.id_shamt;
            r_aluop    <= bus.id_aluop;
            r_alusrc   <= bus.id_alusrc;
            r_shift    <= bus.id_shift;
            r_regwen   <= bus.id_regwen;
            r_memread  <= bus.id_memread;
            r_memwrite <= bus.id_memwrite;
        end
    end

    // Forwarding mux: MEM is younger than WB, so it wins
    always_comb begin
        w_fwd_rs = r_rs_data;
        w_fwd_rt = r_rt_data;
        if (w_mem_hit_rs) begin
            w_fwd_rs = bus.mem_result;
        end else if (w_wb_hit_rs) begin
            w_fwd_rs = bus.wb_data;
        end
        if (w_mem_hit_rt) begin
            w_fwd_rt = bus.mem_result;
        end else if (w_wb_hit_rt) begin
            w_fwd_rt = bus.wb_data;
        end
    end

    // Immediate extension selected by alusrc
    always_comb begin
        w_imm_ext = '0;
        case (r_alusrc)
            c_SRC_SEXT: w_imm_ext = {{(DW-16){r_imm16[15]}}, r_imm16};
            c_SRC_ZEXT: w_imm_ext = {{(DW-16){1'b0}}, r_imm16};
            c_SRC_LUI:  w_imm_ext = {r_imm16, {(DW-16){1'b0}}};
            default:    w_imm_ext = '0;
        endcase
    end

    // Operand select: shifts take rt as the value and shamt as the distance
    always_comb begin
        w_portA = w_fwd_rs;
        w_portB = w_fwd_rt;
        if (r_shift) begin
            w_portA = w_fwd_rt;
            w_portB = {{(DW-5){1'b0}}, r_shamt};
        end else if (r_alusrc != c_SRC_RT) begin
            w_portB = w_imm_ext;
        end
    end

    assign bus.ex_valid      = r_valid;
    assign bus.ex_portA      = w_portA;
    assign bus.ex_portB      = w_portB;
    assign bus.ex_aluop      = r_aluop;
    assign bus.ex_store_data = w_fwd_rt;
    assign bus.ex_dest       = r_dest;
    assign bus.ex_pc         = r_pc;
    // side-effecting controls are suppressed for bubbles
    assign bus.ex_regwen     = r_valid & r_regwen;
    assign bus.ex_memread    = r_valid & r_memread;
    assign bus.ex_memwrite   = r_valid & r_memwrite;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_operand_stage
//  Description : Self-checking bench for id_ex_operand_stage: directed
//                scenarios followed by randomized traffic against a
//                behavioural model of the EX-stage contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    id_ex_operand_stage_if bus ();

    id_ex_operand_stage dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // what the EX stage is supposed to be holding
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [4:0]  dest;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [3:0]  aluop;
        logic [1:0]  src;
        logic        shift;
        logic        regwen;
        logic        memread;
        logic        memwrite;
    } ex_t;

    ex_t m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // value of a register as seen in EX: youngest in-flight writer wins, $0 never bypassed
    function automatic logic [31:0] reg_value(input logic [4:0] idx, input logic [31:0] latched);
        if (idx == 5'd0) return latched;
        if (bus.mem_regwen && bus.mem_dest == idx) return bus.mem_result;
        if (bus.wb_regwen && bus.wb_dest == idx) return bus.wb_data;
        return latched;
    endfunction

    function automatic logic [31:0] exp_portA();
        return m.shift ? reg_value(m.rt, m.rtd) : reg_value(m.rs, m.rsd);
    endfunction

    function automatic logic [31:0] exp_portB();
        int signed simm;
        if (m.shift) return 32'(m.shamt);
        simm = int'($signed(m.imm));
        case (m.src)
            2'd0:    return reg_value(m.rt, m.rtd);
            2'd1:    return 32'(simm);
            2'd2:    return 32'(m.imm);
            default: return 32'(m.imm) * 32'd65536;
        endcase
    endfunction

    // model of one rising edge
    task automatic model_edge();
        if (!nRST) begin
            m = '0;
        end else if (bus.flush) begin
            m.valid    = 1'b0;
            m.regwen   = 1'b0;
            m.memread  = 1'b0;
            m.memwrite = 1'b0;
        end else if (bus.stall) begin
            if (bus.wb_regwen && bus.wb_dest != 5'd0 && bus.wb_dest == m.rs) m.rsd = bus.wb_data;
            if (bus.wb_regwen && bus.wb_dest != 5'd0 && bus.wb_dest == m.rt) m.rtd = bus.wb_data;
        end else begin
            m.valid    = bus.id_valid;
            m.pc       = bus.id_pc;
            m.rs       = bus.id_rs;
            m.rt       = bus.id_rt;
            m.rsd      = bus.id_rs_data;
            m.rtd      = bus.id_rt_data;
            m.dest     = bus.id_dest;
            m.imm      = bus.id_imm16;
            m.shamt    = bus.id_shamt;
            m.aluop    = bus.id_aluop;
            m.src      = bus.id_alusrc;
            m.shift    = bus.id_shift;
            m.regwen   = bus.id_regwen;
            m.memread  = bus.id_memread;
            m.memwrite = bus.id_memwrite;
        end
    endtask

    // compare all outputs; data fields only matter for a real instruction
    task automatic check_all(input string ctx);
        check({ctx, ".valid"},    32'(bus.ex_valid),    32'(m.valid));
        check({ctx, ".regwen"},   32'(bus.ex_regwen),   32'(m.valid & m.regwen));
        check({ctx, ".memread"},  32'(bus.ex_memread),  32'(m.valid & m.memread));
        check({ctx, ".memwrite"}, 32'(bus.ex_memwrite), 32'(m.valid & m.memwrite));
        if (m.valid) begin
            check({ctx, ".portA"}, bus.ex_portA, exp_portA());
            check({ctx, ".portB"}, bus.ex_portB, exp_portB());
            check({ctx, ".store"}, bus.ex_store_data, reg_value(m.rt, m.rtd));
            check({ctx, ".aluop"}, 32'(bus.ex_aluop), 32'(m.aluop));
            check({ctx, ".dest"},  32'(bus.ex_dest),  32'(m.dest));
            check({ctx, ".pc"},    bus.ex_pc, m.pc);
        end
    endtask

    task automatic cycle(input string ctx);
        @(posedge CLK);
        model_edge();
        #1;
        check_all(ctx);
    endtask

    task automatic idle_inputs();
        bus.stall = 1'b0;       bus.flush = 1'b0;
        bus.id_valid = 1'b0;    bus.id_pc = '0;
        bus.id_rs = '0;         bus.id_rt = '0;
        bus.id_rs_data = '0;    bus.id_rt_data = '0;
        bus.id_dest = '0;       bus.id_imm16 = '0;
        bus.id_shamt = '0;      bus.id_aluop = '0;
        bus.id_alusrc = '0;     bus.id_shift = 1'b0;
        bus.id_regwen = 1'b0;   bus.id_memread = 1'b0;
        bus.id_memwrite = 1'b0;
        bus.mem_regwen = 1'b0;  bus.mem_dest = '0;  bus.mem_result = '0;
        bus.wb_regwen = 1'b0;   bus.wb_dest = '0;   bus.wb_data = '0;
    endtask

    task automatic zero_outputs(input string ctx);
        check({ctx, ".valid"},  32'(bus.ex_valid), 32'd0);
        check({ctx, ".portA"},  bus.ex_portA, 32'd0);
        check({ctx, ".portB"},  bus.ex_portB, 32'd0);
        check({ctx, ".aluop"},  32'(bus.ex_aluop), 32'd0);
        check({ctx, ".store"},  bus.ex_store_data, 32'd0);
        check({ctx, ".pc"},     bus.ex_pc, 32'd0);
        check({ctx, ".ctl"},    32'({bus.ex_regwen, bus.ex_memread, bus.ex_memwrite}), 32'd0);
    endtask

    initial begin
        m = '0;
        idle_inputs();

        // reset while stalled with a live instruction on ID
        nRST = 1'b0;
        bus.stall = 1'b1;
        bus.id_valid = 1'b1; bus.id_pc = 32'h1234; bus.id_rs_data = 32'h77;
        bus.id_regwen = 1'b1; bus.id_alusrc = 2'b01; bus.id_imm16 = 16'h8000;
        for (int i = 0; i < 2; i++) begin
            cycle("rst");
            zero_outputs("rst");
        end
        idle_inputs();
        nRST = 1'b1;
        cycle("post_rst");
        zero_outputs("post_rst");

        // ADDI $3,$1,-4
        bus.id_valid = 1'b1; bus.id_pc = 32'h100; bus.id_rs = 5'd1; bus.id_rt = 5'd3;
        bus.id_rs_data = 32'h10; bus.id_dest = 5'd3; bus.id_imm16 = 16'hFFFC;
        bus.id_alusrc = 2'b01; bus.id_regwen = 1'b1; bus.id_aluop = 4'd2;
        cycle("addi");
        check("addi_portA", bus.ex_portA, 32'h10);
        check("addi_portB", bus.ex_portB, 32'hFFFFFFFC);
        check("addi_valid", 32'(bus.ex_valid), 32'd1);
        check("addi_regwen", 32'(bus.ex_regwen), 32'd1);

        // MEM beats WB, then WB alone, then $0 never forwarded
        idle_inputs();
        bus.id_valid = 1'b1; bus.id_rs = 5'd2; bus.id_rt = 5'd2; bus.id_rs_data = 32'h1111;
        bus.id_rt_data = 32'h1111; bus.id_regwen = 1'b1;
        bus.mem_regwen = 1'b1; bus.mem_dest = 5'd2; bus.mem_result = 32'hAAAA;
        bus.wb_regwen = 1'b1;  bus.wb_dest = 5'd2;  bus.wb_data = 32'hBBBB;
        cycle("fwd_mem");
        check("fwd_mem_portA", bus.ex_portA, 32'hAAAA);
        bus.mem_regwen = 1'b0;
        #1;
        check("fwd_wb_portA", bus.ex_portA, 32'hBBBB);
        check_all("fwd_wb");
        bus.id_rs = 5'd0; bus.id_rs_data = 32'h5555;
        bus.mem_regwen = 1'b1; bus.mem_dest = 5'd0;
        bus.wb_dest = 5'd0;
        cycle("fwd_r0");
        check("fwd_r0_portA", bus.ex_portA, 32'h5555);

        // SLL $4,$5,7
        idle_inputs();
        bus.id_valid = 1'b1; bus.id_rs = 5'd0; bus.id_rt = 5'd5; bus.id_rt_data = 32'h3;
        bus.id_shamt = 5'd7; bus.id_shift = 1'b1; bus.id_dest = 5'd4; bus.id_regwen = 1'b1;
        cycle("sll");
        check("sll_portA", bus.ex_portA, 32'h3);
        check("sll_portB", bus.ex_portB, 32'd7);

        // LUI
        idle_inputs();
        bus.id_valid = 1'b1; bus.id_imm16 = 16'h1234; bus.id_alusrc = 2'b11;
        bus.id_dest = 5'd8; bus.id_regwen = 1'b1;
        cycle("lui");
        check("lui_portB", bus.ex_portB, 32'h12340000);

        // stall with WB retiring rt during the hold
        idle_inputs();
        bus.id_valid = 1'b1; bus.id_pc = 32'h40; bus.id_rs = 5'd4; bus.id_rt = 5'd6;
        bus.id_rs_data = 32'h100; bus.id_rt_data = 32'h1; bus.id_imm16 = 16'h8;
        bus.id_alusrc = 2'b01; bus.id_memwrite = 1'b1; bus.id_aluop = 4'd2;
        cycle("sw_cap");
        bus.stall = 1'b1;
        bus.id_pc = 32'h999; bus.id_rt_data = 32'hDEAD; bus.id_memwrite = 1'b0;
        cycle("stall1");
        check("stall1_pc", bus.ex_pc, 32'h40);
        bus.wb_regwen = 1'b1; bus.wb_dest = 5'd6; bus.wb_data = 32'hCAFE;
        cycle("stall2");
        bus.wb_regwen = 1'b0;
        #1;
        check("stall2_store", bus.ex_store_data, 32'hCAFE);
        cycle("stall3");
        check("stall3_store", bus.ex_store_data, 32'hCAFE);
        check("stall3_pc", bus.ex_pc, 32'h40);
        check("stall3_memwrite", 32'(bus.ex_memwrite), 32'd1);

        // stall and flush together: flush wins
        idle_inputs();
        bus.id_valid = 1'b1; bus.id_rt = 5'd7; bus.id_rt_data = 32'h55; bus.id_memwrite = 1'b1;
        bus.id_alusrc = 2'b01;
        cycle("sw2_cap");
        bus.stall = 1'b1; bus.flush = 1'b1;
        cycle("stflush");
        check("stflush_valid", 32'(bus.ex_valid), 32'd0);
        check("stflush_memwrite", 32'(bus.ex_memwrite), 32'd0);
        idle_inputs();
        bus.id_valid = 1'b1; bus.id_rs = 5'd9; bus.id_rt = 5'd10; bus.id_rs_data = 32'h7;
        bus.id_rt_data = 32'h9; bus.id_regwen = 1'b1; bus.id_dest = 5'd11;
        cycle("after_flush");
        check("after_flush_valid", 32'(bus.ex_valid), 32'd1);
        check("after_flush_portB", bus.ex_portB, 32'h9);

        // randomized traffic; small register range so bypasses actually hit
        for (int i = 0; i < 400; i++) begin
            nRST            = ($urandom_range(0, 39) != 0);
            bus.stall       = ($urandom_range(0, 3) == 0);
            bus.flush       = ($urandom_range(0, 9) == 0);
            bus.id_valid    = 1'($urandom_range(0, 1));
            bus.id_pc       = $urandom;
            bus.id_rs       = 5'($urandom_range(0, 7));
            bus.id_rt       = 5'($urandom_range(0, 7));
            bus.id_rs_data  = $urandom;
            bus.id_rt_data  = $urandom;
            bus.id_dest     = 5'($urandom_range(0, 7));
            bus.id_imm16    = 16'($urandom);
            bus.id_shamt    = 5'($urandom);
            bus.id_aluop    = 4'($urandom);
            bus.id_alusrc   = 2'($urandom);
            bus.id_shift    = ($urandom_range(0, 4) == 0);
            bus.id_regwen   = 1'($urandom_range(0, 1));
            bus.id_memread  = 1'($urandom_range(0, 1));
            bus.id_memwrite = 1'($urandom_range(0, 1));
            bus.mem_regwen  = 1'($urandom_range(0, 1));
            bus.mem_dest    = 5'($urandom_range(0, 7));
            bus.mem_result  = $urandom;
            bus.wb_regwen   = 1'($urandom_range(0, 1));
            bus.wb_dest     = 5'($urandom_range(0, 7));
            bus.wb_data     = $urandom;
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
